// File: rtl/array_rw_frontend_pkg.sv
// Shared types and default geometry for the array read/write front end.
// Pure declarations: no logic, no latency.
// Backpressure is handled by the users of these types.
package array_rw_frontend_pkg;

  // Default geometry of the attached array macro
  localparam int AR_ADDR_W       = 2;
  localparam int AR_LANES        = 4;
  localparam int AR_LANE_W       = 114;
  localparam int AR_DATA_W       = AR_LANES * AR_LANE_W;
  localparam int AR_ENTRIES      = 1 << AR_ADDR_W;
  localparam int AR_RESP_DEPTH   = 4;
  localparam int AR_OCC_W        = $clog2(AR_RESP_DEPTH + 1);
  localparam int AR_STARVE_LIMIT = 4;

  // Controller phase: zero-fill sweep, then normal service
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One macro command; it lives in a register for exactly one cycle
  typedef struct packed {
    logic                 en;
    logic                 wmode;
    logic [AR_ADDR_W-1:0] addr;
    logic [AR_LANES-1:0]  wmask;
    logic [AR_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/array_resp_fifo.sv
// Read-response buffer: DATA_W x DEPTH synchronous FIFO with occupancy output.
// Latency: a push is visible on o_valid/o_data the cycle after it is written.
// Backpressure: a push while full is ignored unless a pop happens in the same cycle.
module array_resp_fifo
  import array_rw_frontend_pkg::*;
#(
  parameter int DATA_W = AR_DATA_W,
  parameter int DEPTH  = AR_RESP_DEPTH,
  parameter int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [OCC_W-1:0]  o_occ
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  // Pointers wrap at DEPTH so non-power-of-two depths work too
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == OCC_W'(DEPTH));
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  // Storage array; contents are don't-care while the entry is not occupied
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves occupancy alone
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_occ   = r_occ;

endmodule

// File: rtl/array_rw_frontend.sv
// Arbitrates write/read request channels onto a single-port lane-masked SRAM, zero-filling it after reset.
// Latency: command on the macro 1 cycle after handshake; read response valid 3 cycles after handshake.
// Backpressure: reads need a response-buffer credit; writes always proceed; reads win after STARVE_LIMIT losses.
module array_rw_frontend
  import array_rw_frontend_pkg::*;
#(
  parameter int ADDR_W       = AR_ADDR_W,
  parameter int LANES        = AR_LANES,
  parameter int LANE_W       = AR_LANE_W,
  parameter int RESP_DEPTH   = AR_RESP_DEPTH,
  parameter int STARVE_LIMIT = AR_STARVE_LIMIT,
  localparam int DATA_W      = LANES * LANE_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [LANES-1:0]  i_wr_mask,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_data,
  output logic              o_init_done,
  output logic              o_sram_en,
  output logic              o_sram_wmode,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [LANES-1:0]  o_sram_wmask,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic [DATA_W-1:0] i_sram_rdata
);

  localparam int ENTRIES = 2 ** ADDR_W;
  localparam int OCC_W   = $clog2(RESP_DEPTH + 1);
  localparam int CRD_W   = OCC_W + 2;
  localparam int CNT_W   = ADDR_W + 1;
  localparam int SC_W    = $clog2(STARVE_LIMIT + 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_init_cnt;
  cmd_t             r_cmd;
  logic             r_rd_stage;
  logic             r_init_done;
  logic [SC_W-1:0]  r_starve;

  logic [OCC_W-1:0] w_occ;
  logic             w_resp_valid;
  logic             w_resp_fire;
  logic             w_cmd_is_rd;
  logic [CRD_W-1:0] w_committed;
  logic [CRD_W-1:0] w_capacity;
  logic             w_rd_credit;
  logic             w_starve_hit;
  logic             w_run;
  logic             w_rd_grant;
  logic             w_wr_grant;

  // A read occupies a buffer slot from grant until popped: command stage, macro stage, FIFO
  assign w_cmd_is_rd = r_cmd.en && !r_cmd.wmode;
  assign w_resp_fire = w_resp_valid && i_resp_ready;
  assign w_committed = CRD_W'(w_occ) + CRD_W'(w_cmd_is_rd) + CRD_W'(r_rd_stage);
  assign w_capacity  = CRD_W'(RESP_DEPTH) + CRD_W'(w_resp_fire);
  assign w_rd_credit = (w_committed < w_capacity);

  // Writes have priority unless the read side has lost STARVE_LIMIT times in a row
  assign w_starve_hit = (r_starve == SC_W'(STARVE_LIMIT));
  assign w_run        = (r_state == ST_RUN) && !i_reset;
  assign w_rd_grant   = w_run && i_rd_valid && w_rd_credit && (!i_wr_valid || w_starve_hit);
  assign w_wr_grant   = w_run && i_wr_valid && !w_rd_grant;

  assign o_wr_ready = w_wr_grant;
  assign o_rd_ready = w_rd_grant;

  // Phase control and the one-cycle command register driving the macro
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_INIT;
      r_init_cnt  <= '0;
      r_cmd       <= '0;
      r_init_done <= 1'b0;
      r_rd_stage  <= 1'b0;
    end else begin
      r_rd_stage <= w_cmd_is_rd;
      case (r_state)
        ST_INIT: begin
          if (r_init_cnt == CNT_W'(ENTRIES)) begin
            r_state     <= ST_RUN;
            r_init_done <= 1'b1;
            r_cmd       <= '0;
          end else begin
            r_cmd.en    <= 1'b1;
            r_cmd.wmode <= 1'b1;
            r_cmd.addr  <= r_init_cnt[ADDR_W-1:0];
            r_cmd.wmask <= '1;
            r_cmd.wdata <= '0;
            r_init_cnt  <= r_init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (w_rd_grant) begin
            r_cmd.en    <= 1'b1;
            r_cmd.wmode <= 1'b0;
            r_cmd.addr  <= i_rd_addr;
            r_cmd.wmask <= '0;
            r_cmd.wdata <= '0;
          end else if (w_wr_grant) begin
            r_cmd.en    <= 1'b1;
            r_cmd.wmode <= 1'b1;
            r_cmd.addr  <= i_wr_addr;
            r_cmd.wmask <= i_wr_mask;
            r_cmd.wdata <= i_wr_data;
          end else begin
            r_cmd <= '0;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // Count consecutive cycles a creditable read lost to a write
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_starve <= '0;
    end else if (w_rd_grant) begin
      r_starve <= '0;
    end else if (w_wr_grant && i_rd_valid && w_rd_credit && !w_starve_hit) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Macro read data is captured the cycle after the read command; credit guarantees room
  array_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH),
    .OCC_W  (OCC_W)
  ) u_resp_fifo (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_push      (r_rd_stage),
    .i_push_data (i_sram_rdata),
    .i_pop       (i_resp_ready),
    .o_valid     (w_resp_valid),
    .o_data      (o_resp_data),
    .o_occ       (w_occ)
  );

  assign o_resp_valid = w_resp_valid;
  assign o_init_done  = r_init_done;
  assign o_sram_en    = r_cmd.en;
  assign o_sram_wmode = r_cmd.wmode;
  assign o_sram_addr  = r_cmd.addr;
  assign o_sram_wmask = r_cmd.wmask;
  assign o_sram_wdata = r_cmd.wdata;

endmodule

// File: tb/tb_array_rw_frontend.sv
// Bench for array_rw_frontend with a behavioural macro and a scoreboard model.
// Latency: checks init sweep timing, 3-cycle read latency, back-to-back throughput.
// Backpressure: exercises response stall, write-over-read arbitration and reset mid-flight.
module tb_array_rw_frontend;

  localparam int ADDR_W  = 2;
  localparam int LANES   = 4;
  localparam int LANE_W  = 114;
  localparam int DATA_W  = LANES * LANE_W;
  localparam int ENTRIES = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANES-1:0]  wr_mask;
  word_t             wr_data;
  logic              rd_valid, rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              resp_valid, resp_ready;
  word_t             resp_data;
  logic              init_done;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [LANES-1:0]  sram_wmask;
  word_t             sram_wdata, sram_rdata;

  int n_chk = 0;
  int n_err = 0;
  int dual_cnt = 0;

  word_t sram_mem [ENTRIES];
  logic  scrambled = 1'b0;
  word_t model_mem [ENTRIES];
  word_t exp_q [$];

  always #5 clk = ~clk;

  array_rw_frontend dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_wr_valid   (wr_valid),
    .o_wr_ready   (wr_ready),
    .i_wr_addr    (wr_addr),
    .i_wr_mask    (wr_mask),
    .i_wr_data    (wr_data),
    .i_rd_valid   (rd_valid),
    .o_rd_ready   (rd_ready),
    .i_rd_addr    (rd_addr),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_data  (resp_data),
    .o_init_done  (init_done),
    .o_sram_en    (sram_en),
    .o_sram_wmode (sram_wmode),
    .o_sram_addr  (sram_addr),
    .o_sram_wmask (sram_wmask),
    .o_sram_wdata (sram_wdata),
    .i_sram_rdata (sram_rdata)
  );

  function automatic word_t rand_data();
    logic [479:0] t;
    for (int i = 0; i < 480; i += 32) t[i +: 32] = $urandom;
    return t[DATA_W-1:0];
  endfunction

  task automatic chk(input string tag, input word_t got, input word_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Behavioural single-port macro: garbage on rdata except the cycle after a read
  always @(posedge clk) begin
    if (!scrambled) begin
      for (int a = 0; a < ENTRIES; a++) sram_mem[a] <= rand_data();
      scrambled <= 1'b1;
    end else if (sram_en && sram_wmode) begin
      for (int l = 0; l < LANES; l++)
        if (sram_wmask[l]) sram_mem[sram_addr][l*LANE_W +: LANE_W] <= sram_wdata[l*LANE_W +: LANE_W];
    end
    if (sram_en && !sram_wmode) sram_rdata <= sram_mem[sram_addr];
    else sram_rdata <= rand_data();
  end

  // Scoreboard: array contents after accepted writes, responses in acceptance order
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      for (int a = 0; a < ENTRIES; a++) model_mem[a] = '0;
    end else begin
      if (wr_valid && wr_ready && rd_valid && rd_ready) dual_cnt++;
      if (wr_valid && wr_ready)
        for (int l = 0; l < LANES; l++)
          if (wr_mask[l]) model_mem[wr_addr][l*LANE_W +: LANE_W] = wr_data[l*LANE_W +: LANE_W];
      if (rd_valid && rd_ready) exp_q.push_back(model_mem[rd_addr]);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("resp_unexpected", word_t'(resp_valid), word_t'(1'b0));
        else chk("resp_data", resp_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_sweep();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outs", word_t'({wr_ready, rd_ready, resp_valid, init_done, sram_en, sram_wmode, sram_wmask}), word_t'(0));
    chk("rst_resp_data", resp_data, word_t'(0));
    for (int k = 0; k < ENTRIES; k++) begin
      @(negedge clk);
      chk("init_cmd", word_t'({sram_en, sram_wmode, sram_addr, sram_wmask, init_done, wr_ready, rd_ready}),
          word_t'({1'b1, 1'b1, ADDR_W'(k), 4'hF, 3'b000}));
      chk("init_wdata", sram_wdata, word_t'(0));
    end
    tick();
  endtask

  task automatic do_wr(input logic [ADDR_W-1:0] a, input logic [LANES-1:0] m, input word_t d);
    logic got;
    got = 1'b0;
    wr_valid = 1'b1; wr_addr = a; wr_mask = m; wr_data = d;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (wr_ready) got = 1'b1;
      else tick();
    end
    chk("wr_accept", word_t'(got), word_t'(1'b1));
    if (got) tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_rd(input logic [ADDR_W-1:0] a);
    logic got;
    got = 1'b0;
    rd_valid = 1'b1; rd_addr = a;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (rd_ready) got = 1'b1;
      else tick();
    end
    chk("rd_accept", word_t'(got), word_t'(1'b1));
    if (got) tick();
    rd_valid = 1'b0;
  endtask

  task automatic wait_resp(output word_t d);
    logic got;
    got = 1'b0;
    d = '0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        d = resp_data;
      end
    end
    chk("resp_timeout", word_t'(got), word_t'(1'b1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    word_t d, e;
    int acc, wait_cnt, max_wait;

    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_mask = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_rst_outs", word_t'({wr_ready, rd_ready, resp_valid, init_done, sram_en}), word_t'(0));
    tick();

    // Init sweep, then a read of addr 2 right as init_done rises
    do_reset_sweep();
    rd_valid = 1'b1; rd_addr = 2'd2;
    @(negedge clk);
    chk("run_state", word_t'({init_done, sram_en, rd_ready, wr_ready}), word_t'(4'b1010));
    tick();
    rd_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("rd_lat_vld", word_t'(resp_valid), word_t'(i == 3));
      if (i == 3) chk("rd_lat_data", resp_data, word_t'(0));
      tick();
    end

    // Masked write then read-back
    e = '0;
    for (int l = 0; l < LANES; l += 2) e[l*LANE_W +: LANE_W] = '1;
    do_wr(2'd1, 4'b0101, '1);
    do_rd(2'd1);
    wait_resp(d);
    chk("mask_merge", d, e);
    tick();

    // Preload then back-to-back reads at full rate
    for (int a = 0; a < ENTRIES; a++) do_wr(ADDR_W'(a), 4'hF, rand_data());
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin rd_valid = 1'b1; rd_addr = ADDR_W'(i); end
      else rd_valid = 1'b0;
      @(negedge clk);
      if (i < 4) chk("b2b_rdy", word_t'(rd_ready), word_t'(1'b1));
      chk("b2b_rvld", word_t'(resp_valid), word_t'(i >= 3 && i <= 6));
      tick();
    end

    // Response stall: exactly RESP_DEPTH reads accepted, writes still flow
    resp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      rd_valid = 1'b1; rd_addr = ADDR_W'($urandom_range(0, ENTRIES - 1));
      if (i == 9) begin
        wr_valid = 1'b1; wr_addr = ADDR_W'($urandom_range(0, ENTRIES - 1));
        wr_mask = LANES'($urandom); wr_data = rand_data();
      end
      @(negedge clk);
      if (rd_ready) acc++;
      if (i == 9) chk("full_wr_ok", word_t'(wr_ready), word_t'(1'b1));
      if (i == 11) chk("full_rd_blocked", word_t'(rd_ready), word_t'(1'b0));
      tick();
      wr_valid = 1'b0;
    end
    chk("stall_accepts", word_t'(acc), word_t'(4));
    resp_ready = 1'b1;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      rd_valid = 1'b1; rd_addr = ADDR_W'($urandom_range(0, ENTRIES - 1));
      @(negedge clk);
      if (rd_ready) acc++;
      tick();
    end
    rd_valid = 1'b0;
    chk("resume_accepts", word_t'(acc), word_t'(10));
    repeat (8) tick();
    @(negedge clk);
    chk("drain_vld", word_t'(resp_valid), word_t'(1'b0));
    tick();

    // Both channels saturated: four writes then one read, repeating
    wait_cnt = 0; max_wait = 0;
    for (int i = 0; i < 20; i++) begin
      wr_valid = 1'b1; wr_addr = ADDR_W'($urandom_range(0, ENTRIES - 1));
      wr_mask = LANES'($urandom); wr_data = rand_data();
      rd_valid = 1'b1; rd_addr = ADDR_W'($urandom_range(0, ENTRIES - 1));
      @(negedge clk);
      chk("arb_rd", word_t'(rd_ready), word_t'((i % 5) == 4));
      chk("arb_wr", word_t'(wr_ready), word_t'((i % 5) != 4));
      if (rd_ready) wait_cnt = 0;
      else wait_cnt++;
      if (wait_cnt > max_wait) max_wait = wait_cnt;
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    chk("rd_wait_bound", word_t'(max_wait <= 4), word_t'(1'b1));
    repeat (6) tick();

    // Reset with two responses buffered and one read in flight
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1; rd_addr = ADDR_W'(i);
      @(negedge clk);
      chk("t6_rdy", word_t'(rd_ready), word_t'(1'b1));
      tick();
    end
    rd_valid = 1'b0;
    @(negedge clk);
    chk("t6_buffered", word_t'(resp_valid), word_t'(1'b1));
    tick();
    do_reset_sweep();
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_stale", word_t'(resp_valid), word_t'(1'b0));
      tick();
    end
    do_rd(2'd3);
    wait_resp(d);
    chk("post_rst_rd", d, word_t'(0));
    tick();
    repeat (4) tick();

    chk("dual_grant", word_t'(dual_cnt), word_t'(0));
    chk("resp_left", word_t'(exp_q.size()), word_t'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/array_rw_frontend.md
# array_rw_frontend

Initiator-side controller for a single-port, lane-masked SRAM macro with one RW port: one enable, a write-mode select, a per-lane write mask, and read data returned one cycle after the read command. It accepts independent write and read request channels (valid/ready) and arbitrates them onto the single port. On every reset it zero-initialises the array, and it returns read data through a credit-protected response buffer with backpressure. It sits between a cache/predictor pipeline and its `*_ext` array macro.

## Interface
Parameters:
- ADDR_W, 2, array address width; ENTRIES = 2**ADDR_W
- LANES, 4, write-mask lanes
- LANE_W, 114, bits per lane; DATA_W = LANES*LANE_W (456)
- RESP_DEPTH, 4, response buffer entries (≥3 for full read throughput)
- STARVE_LIMIT, 4, consecutive read losses before read is forced to win

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- wr_valid / wr_ready  in / out  1  write request handshake
- wr_addr  in  ADDR_W  write address
- wr_mask  in  LANES  lane write enables
- wr_data  in  DATA_W  write data
- rd_valid / rd_ready  in / out  1  read request handshake
- rd_addr  in  ADDR_W  read address
- resp_valid / resp_ready  out / in  1  read response handshake
- resp_data  out  DATA_W  read data, in request order
- init_done  out  1  high once the init sweep completes
- sram_en, sram_wmode  out  1  macro enable and write mode
- sram_addr  out  ADDR_W
- sram_wmask  out  LANES
- sram_wdata  out  DATA_W
- sram_rdata  in  DATA_W  macro read data, valid only in the cycle after a read command

## Operation
- FSM states:
  - INIT: address counter 0..ENTRIES-1 writes data 0 with an all-ones mask, one entry per cycle. Both readies are low.
  - RUN: entered after the last init write. Never left except through reset.
- Read credit: rd_credit = (occ + inflight) < (RESP_DEPTH + resp_fire).
  - occ is buffer occupancy.
  - inflight is the number of reads in the command register or SRAM stage (0..2).
- Arbitration in RUN, at most one grant per cycle:
  - A read wins if rd_valid && rd_credit && (!wr_valid || starve_cnt == STARVE_LIMIT).
  - Otherwise a write wins if wr_valid.
- wr_ready and rd_ready reflect the grant, so each channel's ready may depend on the other channel's valid.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, when a write is granted while rd_valid && rd_credit.
  - Clears on a read grant.
  - Unchanged otherwise.
- Granted requests load a command register that drives the sram_* outputs for exactly one cycle.
  - Writes: sram_wmode = 1 and wmask = wr_mask.
  - Reads: sram_wmode = 0 and wmask = 0.
  - Idle cycles: sram_en = 0.
- Read data is captured from sram_rdata in the cycle after the read command and pushed into the response FIFO. It is never dropped: the credit rule guarantees space.
- Ordering: the single port serialises all operations. A read granted after a write to the same address returns the new data, masked lanes only.

## Timing
- Reset values: every output is 0, including ready, resp_valid, init_done and sram_en. The FSM is INIT, all counters are 0, and the FIFO is empty.
- INIT: first init write is on sram_* in the cycle after reset deasserts. init_done rises in cycle ENTRIES+1 after reset deasserts. The first grant is possible in that same cycle.
- Write: handshake in cycle t puts the command on sram_* in t+1.
- Read latency: handshake in cycle t puts the command on sram_* in t+1. sram_rdata is valid in t+2. resp_valid is high in t+3 if the FIFO was empty.
- Throughput: sustained 1 op/cycle. With RESP_DEPTH ≥ 3 and resp_ready held high, back-to-back reads sustain 1/cycle.
- FIFO full and resp_ready low: rd_ready stays low (no credit). Writes continue.
- Simultaneous FIFO push and pop: occupancy is unchanged.
- Reset mid-operation:
  - In-flight reads and buffered responses are discarded and the FIFO is emptied.
  - An in-flight write may or may not have landed; the init sweep then overwrites the whole array regardless.
  - The FSM restarts INIT.

## Structure
- Shared package holds:
  - the state enum {INIT, RUN};
  - derived widths DATA_W, ENTRIES and the occupancy counter width $clog2(RESP_DEPTH+1);
  - a command struct {en, wmode, addr, wmask, wdata}.
- One sub-module: array_resp_fifo, a parameterised DATA_W × RESP_DEPTH synchronous FIFO with push/pop and an occupancy output.

## Test plan
- Reset, then idle: sram_en pulses 4 cycles at addr 0,1,2,3 with wmask 4'hF and wdata 0. init_done rises in cycle 5. A read of addr 2 returns 0 three cycles after its handshake.
- Write addr 1 with mask 4'b0101 and lanes all-ones, then read addr 1 → resp_data has lanes 0 and 2 all-ones, lanes 1 and 3 zero.
- Back-to-back reads of addr 0..3 with resp_ready=1 → rd_ready stays high every cycle. Responses arrive in order on 4 consecutive cycles starting 3 cycles after the first handshake.
- resp_ready=0 with continuous rd_valid → exactly RESP_DEPTH (4) reads accepted, then rd_ready=0. Raising resp_ready drains all 4 in order and reads resume.
- wr_valid and rd_valid held high continuously → pattern of 4 write grants then 1 read grant, repeating. No read waits more than 5 cycles.
- Assert reset for 1 cycle with 2 responses buffered and 1 read in flight → resp_valid=0 the next cycle, the init sweep repeats, and no stale response ever appears.
